// File: rtl/riscv_pc_pkg.sv
// Shared constants and types for the program-counter unit.
//   Default XLEN/INC/ALIGN_BITS and reset/trap vectors, plus the PC FSM state type.
package riscv_pc_pkg;

    localparam int unsigned DefXlen        = 32;
    localparam int unsigned DefInc         = 4;
    localparam int unsigned DefAlignBits   = 2;
    localparam logic [31:0] DefResetVector = 32'h0000_0000;
    localparam logic [31:0] DefTrapVector  = 32'h0000_0100;

    // StBoot: out of reset, pc not yet fetchable.
    // StRun:  normal sequencing.
    // StPend: a redirect arrived during a stall and is waiting to be applied.
    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control logic and the PC unit.
//   master: pipeline control side (drives stall/redirect/trap, observes the PC).
//   slave:  pc_unit side (consumes control, drives pc, pc_plus_inc, status flags).
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            redirect_pending;
    logic            misalign_err;

    modport master (
        output stall, redirect_valid, redirect_target, trap,
        input  pc, pc_plus_inc, pc_valid, redirect_pending, misalign_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap,
        output pc, pc_plus_inc, pc_valid, redirect_pending, misalign_err
    );
endinterface

// File: rtl/pc_adder.sv
// Purely combinational sequential-PC adder: sum_o = pc_i + INC, modulo 2^XLEN.
// Also used by the execute-stage link-address path.
//   pc_i  : input PC
//   sum_o : pc_i + INC (wraps silently)
module pc_adder #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned INC  = 4
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] sum_o
);

    localparam logic [XLEN-1:0] IncVal = XLEN'(INC);

    assign sum_o = pc_i + IncVal;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program-counter register with next-PC selection.
// Priority: trap vector > redirect target > hold (stall) > pc + INC.
// A redirect seen during a stall is buffered and applied on the first unstalled edge.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_unit_if.slave (stall, redirect_valid, redirect_target, trap in;
//           pc, pc_plus_inc, pc_valid, redirect_pending, misalign_err out)
//
// Build option: PC_MISALIGN_TRAP_EN -- when defined, a misaligned redirect target
// traps to TRAP_VECTOR and pulses misalign_err; otherwise the low bits are masked off
// and misalign_err is tied low.
module pc_unit
    import riscv_pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DefXlen,
    parameter int unsigned     INC          = DefInc,
    parameter int unsigned     ALIGN_BITS   = DefAlignBits,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefResetVector),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DefTrapVector)
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);

    // Ones in the ALIGN_BITS LSBs; works for ALIGN_BITS = 0 too.
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] pc_plus_inc;
    logic            load_req;
    logic [XLEN-1:0] load_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    pc_adder #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_pc_adder (
        .pc_i  (pc_q),
        .sum_o (pc_plus_inc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        pend_tgt_d = pend_tgt_q;
        load_req   = 1'b0;
        load_tgt   = bus.redirect_target;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif

        case (state_q)
            StBoot: begin
                // pc already holds RESET_VECTOR; only make it fetchable.
                state_d    = StRun;
                pc_valid_d = 1'b1;
            end
            StRun: begin
                if (bus.trap) begin
                    pc_d       = TRAP_VECTOR;
                    pend_tgt_d = '0;
                end else if (bus.redirect_valid && !bus.stall) begin
                    load_req = 1'b1;
                end else if (bus.redirect_valid) begin
                    pend_tgt_d = bus.redirect_target;
                    state_d    = StPend;
                end else if (!bus.stall) begin
                    pc_d = pc_plus_inc;
                end
            end
            StPend: begin
                if (bus.trap) begin
                    pc_d       = TRAP_VECTOR;
                    pend_tgt_d = '0;
                    state_d    = StRun;
                end else if (bus.redirect_valid) begin
                    // Youngest redirect wins; applied now if the stall has cleared.
                    pend_tgt_d = bus.redirect_target;
                    if (!bus.stall) begin
                        load_req = 1'b1;
                        state_d  = StRun;
                    end
                end else if (!bus.stall) begin
                    load_req = 1'b1;
                    load_tgt = pend_tgt_q;
                    state_d  = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (load_req) begin
`ifdef PC_MISALIGN_TRAP_EN
            if ((load_tgt & AlignMask) != '0) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end else begin
                pc_d = load_tgt;
            end
`else
            pc_d = load_tgt & ~AlignMask;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign_err = misalign_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

    assign bus.pc               = pc_q;
    assign bus.pc_plus_inc      = pc_plus_inc;
    assign bus.pc_valid         = pc_valid_q;
    assign bus.redirect_pending = (state_q == StPend);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default parameters).
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] tgt, input logic tr);
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.trap            = tr;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset state
        #3;
        check_eq("rst_pc", bus.pc, 32'h0);
        check_eq("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
        check_eq("rst_pend", {31'b0, bus.redirect_pending}, 32'h0);
        check_eq("rst_err", {31'b0, bus.misalign_err}, 32'h0);

        // Release and sequential fetch
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("boot_pc", bus.pc, 32'h0);
        check_eq("boot_valid", {31'b0, bus.pc_valid}, 32'h1);
        check_eq("boot_inc", bus.pc_plus_inc, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("seq_pc", bus.pc, 32'(4 * i));
        end

        // Redirect during 3-cycle stall, at pc=0x10
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        check_eq("stall0_pc", bus.pc, 32'h10);
        check_eq("stall0_pend", {31'b0, bus.redirect_pending}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        step();
        check_eq("stall2_pc", bus.pc, 32'h10);
        check_eq("stall2_pend", {31'b0, bus.redirect_pending}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_eq("pend_apply_pc", bus.pc, 32'h40);
        check_eq("pend_apply_pend", {31'b0, bus.redirect_pending}, 32'h0);
        step();
        check_eq("after_apply_pc", bus.pc, 32'h44);

        // Trap while pending (with stall still high)
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        check_eq("pend2_pc", bus.pc, 32'h44);
        check_eq("pend2_pend", {31'b0, bus.redirect_pending}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        check_eq("trap_pc", bus.pc, 32'h100);
        check_eq("trap_pend", {31'b0, bus.redirect_pending}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_eq("trap_next_pc", bus.pc, 32'h104);

        // Misaligned redirect target
        drive(1'b0, 1'b1, 32'h22, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("mis_pc", bus.pc, 32'h100);
        check_eq("mis_err", {31'b0, bus.misalign_err}, 32'h1);
        step();
        check_eq("mis_next_pc", bus.pc, 32'h104);
        check_eq("mis_err_clr", {31'b0, bus.misalign_err}, 32'h0);
`else
        check_eq("mis_pc", bus.pc, 32'h20);
        check_eq("mis_err", {31'b0, bus.misalign_err}, 32'h0);
        step();
        check_eq("mis_next_pc", bus.pc, 32'h24);
        check_eq("mis_err_clr", {31'b0, bus.misalign_err}, 32'h0);
`endif

        // Wrap-around
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("wrap0_pc", bus.pc, 32'hFFFF_FFF8);
        check_eq("wrap0_inc", bus.pc_plus_inc, 32'hFFFF_FFFC);
        step();
        check_eq("wrap1_pc", bus.pc, 32'hFFFF_FFFC);
        check_eq("wrap1_inc", bus.pc_plus_inc, 32'h0);
        step();
        check_eq("wrap2_pc", bus.pc, 32'h0);
        check_eq("wrap_err", {31'b0, bus.misalign_err}, 32'h0);

        // Youngest pending redirect wins
        drive(1'b1, 1'b1, 32'h200, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h300, 1'b0);
        step();
        check_eq("young_hold_pc", bus.pc, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check_eq("young_pc", bus.pc, 32'h300);

        // New redirect while pending with stall released: applied directly
        drive(1'b1, 1'b1, 32'h400, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h500, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("direct_pc", bus.pc, 32'h500);
        check_eq("direct_pend", {31'b0, bus.redirect_pending}, 32'h0);

        // Asynchronous reset mid-stall with a pending redirect
        drive(1'b1, 1'b1, 32'h600, 1'b0);
        step();
        check_eq("pre_rst_pend", {31'b0, bus.redirect_pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_pc", bus.pc, 32'h0);
        check_eq("async_rst_valid", {31'b0, bus.pc_valid}, 32'h0);
        check_eq("async_rst_pend", {31'b0, bus.redirect_pending}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("rel_pc", bus.pc, 32'h0);
        check_eq("rel_valid", {31'b0, bus.pc_valid}, 32'h1);
        step();
        check_eq("rel_next_pc", bus.pc, 32'h4);
        check_eq("rel_pend", {31'b0, bus.redirect_pending}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter register that supersedes the combinational PC+4 adder.
- Holds the current fetch PC and selects the next PC from these sources, in priority order: trap vector, redirect target, hold, sequential PC+INC.
- Buffers a redirect that arrives while the pipeline is stalled.
- Sits at the head of the fetch stage; drives instruction-memory address and the PC+INC value used by JAL/JALR link writes.

Parameters:
- XLEN, 32, PC width in bits.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of PC LSBs that must be zero for a legal PC.
- RESET_VECTOR, 32'h0000_0000, PC loaded by reset; XLEN bits.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap; XLEN bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; decode/hazard unit cannot accept a new instruction.
- redirect_valid  in  1  branch taken or jump resolved this cycle.
- redirect_target  in  XLEN  new PC for the redirect.
- trap  in  1  exception request; overrides stall and redirect.
- pc  out  XLEN  current fetch address (registered).
- pc_plus_inc  out  XLEN  pc + INC, combinational, modulo 2^XLEN.
- pc_valid  out  1  pc holds a fetchable address.
- redirect_pending  out  1  a stalled redirect is buffered.
- misalign_err  out  1  one-cycle pulse: illegal redirect target detected.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - pc = RESET_VECTOR, pc_valid = 0, redirect_pending = 0, misalign_err = 0.
  - Pending target register = 0; state = BOOT.
- States:
  - BOOT -> RUN on the first rising edge with rst_n=1. pc is unchanged (RESET_VECTOR) and pc_valid becomes 1. The first fetch is therefore RESET_VECTOR, one cycle after reset release.
  - RUN, per rising edge, first matching rule wins:
    - trap=1: pc <= TRAP_VECTOR; any pending redirect is discarded.
    - redirect_valid=1 and stall=0: pc <= target.
    - redirect_valid=1 and stall=1: target is captured into the pending register; pc unchanged; -> PEND.
    - stall=1: pc unchanged.
    - otherwise: pc <= pc_plus_inc.
  - PEND (redirect_pending=1), per rising edge:
    - trap=1: pc <= TRAP_VECTOR; -> RUN.
    - A new redirect_valid=1 overwrites the pending target (youngest wins). If stall=0 in the same cycle, the new target is applied directly and the state -> RUN.
    - stall=1: hold pc.
    - stall=0: pc <= pending target; -> RUN.
- Latency:
  - Redirect with no stall: 1 cycle.
  - Redirect buffered during stall: applied on the first edge with stall=0.
- Arithmetic:
  - pc_plus_inc = pc + INC, truncated to XLEN.
  - Wrap-around is legal: for XLEN=32, INC=4, 32'hFFFF_FFFC -> 32'h0000_0000. No flag is raised.
- Alignment (feature macro undefined):
  - The ALIGN_BITS LSBs of any loaded target are forced to 0.
  - misalign_err stays 0.
- Reset mid-operation: asynchronous; all state clears immediately, including the pending redirect.
- Simultaneous stall and trap: the trap is taken; stall is ignored for that edge.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with nonzero ALIGN_BITS LSBs is not loaded. pc <= TRAP_VECTOR and misalign_err = 1 for exactly one cycle, registered in the same edge as the load.
  - The check applies both at direct application and at application of a pending target.
  - A misaligned target captured during stall is kept in the pending register until it is applied (then trapped) or discarded by a trap.
- Undefined: LSBs are masked as above; misalign_err is tied to 0.

Decomposition:
- Package riscv_pc_pkg holds:
  - Default XLEN, INC, ALIGN_BITS, RESET_VECTOR, TRAP_VECTOR constants.
  - The state enumeration: BOOT, RUN, PEND.
- Sub-module pc_adder, parametrised on XLEN and INC.
  - Purely combinational pc + INC.
  - Reused by the link-address path in the execute stage.

Test Plan:
- Reset release, then 5 clean cycles: pc_valid rises 1 cycle after rst_n; pc sequence is 0x0, 0x4, 0x8, 0xC, 0x10.
- Wrap: pc reaches 0xFFFFFFF8, then 2 clean cycles -> 0xFFFFFFFC, 0x00000000; no misalign_err.
- At pc=0x10, stall=1 for 3 cycles with redirect_valid=1, target 0x40, on the first stall cycle only:
  - pc stays 0x10 and redirect_pending=1.
  - First edge after stall drops: pc=0x40, then 0x44.
- While in PEND (target 0x40), assert trap: pc=TRAP_VECTOR 0x100, redirect_pending=0, then 0x104.
- Redirect target 0x22:
  - Without macro: pc=0x20.
  - With PC_MISALIGN_TRAP_EN: pc=0x100 and misalign_err high for exactly 1 cycle.
- Assert rst_n=0 mid-stall with a pending redirect: pc=RESET_VECTOR and pc_valid=0 immediately, without waiting for a clock edge; after release the sequence restarts from 0x0.
